// File: rtl/vending_pkg.sv
// Shared state encoding, credit constants and next-state helper for the can vending controller.
package vending_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    C05      = 3'd1,
    C10      = 3'd2,
    VEND     = 3'd3,
    VEND_CHG = 3'd4
  } state_t;

  // Credit is counted in half-units so every coin value is an integer.
  localparam int unsigned PRICE = 3;
  localparam int unsigned ONE   = 2;
  localparam int unsigned HALF  = 1;

  function automatic state_t next_state(input state_t state, input logic one, input logic half);
    int unsigned credit;
    int unsigned coin;
    int unsigned total;
    state_t      result;
    credit = (state == C05) ? HALF : (state == C10) ? ONE : 0;
    // A simultaneous half coin is rejected when a one coin is present.
    coin   = one ? ONE : (half ? HALF : 0);
    total  = credit + coin;
    if (total > PRICE)       result = VEND_CHG;
    else if (total == PRICE) result = VEND;
    else if (total == ONE)   result = C10;
    else if (total == HALF)  result = C05;
    else                     result = IDLE;
    return result;
  endfunction

endpackage

// File: rtl/vending_machine.sv
// Moore FSM for the can dispenser: tracks coin credit and pulses can/change actuators on a vend.
module vending_machine
  import vending_pkg::*;
(
  output logic can_out,
  output logic change_out,
  input  logic clk,
  input  logic reset,
  input  logic one_in,
  input  logic half_in
);

  state_t state;
  state_t state_nxt;

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE, C05, C10, VEND, VEND_CHG: state_nxt = next_state(state, one_in, half_in);
      default:                        state_nxt = IDLE;
    endcase
  end

  // NOTE: outputs are registered from the next state, so they always equal a decode of the
  // current state register and never see a combinational path from the coin inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      can_out    <= 1'b0;
      change_out <= 1'b0;
    end else begin
      state      <= state_nxt;
      can_out    <= (state_nxt == VEND) || (state_nxt == VEND_CHG);
      change_out <= (state_nxt == VEND_CHG);
    end
  end

endmodule

// File: tb/tb_vending_machine.sv
// Directed self-checking bench for vending_machine: coin sequences, vends, change and async reset.
module tb_vending_machine;
  import vending_pkg::*;

  logic can_out;
  logic change_out;
  logic clk;
  logic reset;
  logic one_in;
  logic half_in;

  int checks   = 0;
  int failures = 0;

  vending_machine dut (
    .can_out    (can_out),
    .change_out (change_out),
    .clk        (clk),
    .reset      (reset),
    .one_in     (one_in),
    .half_in    (half_in)
  );

  // Rising edges at multiples of 100 ns.
  initial begin
    clk = 1'b0;
    #100;
    forever begin
      clk = 1'b1;
      #50;
      clk = 1'b0;
      #50;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input state_t exp_state, input logic exp_can,
                           input logic exp_chg);
    check({tag, ".state"},  int'(dut.state), int'(exp_state));
    check({tag, ".can"},    int'(can_out),   int'(exp_can));
    check({tag, ".change"}, int'(change_out), int'(exp_chg));
  endtask

  // Called at a falling edge: drive coins, let one rising edge pass, return at the next falling edge.
  task automatic cyc(input logic one, input logic half);
    one_in  = one;
    half_in = half;
    @(posedge clk);
    @(negedge clk);
    one_in  = 1'b0;
    half_in = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    one_in  = 1'b1;
    half_in = 1'b1;

    // 1. Reset held across the edge at 100 ns with coins present.
    #110;
    check_all("reset_hold", IDLE, 1'b0, 1'b0);
    #10;
    reset   = 1'b0;
    one_in  = 1'b0;
    half_in = 1'b0;
    @(negedge clk);
    check_all("reset_release", IDLE, 1'b0, 1'b0);

    // 2. one_in for three edges: C10, VEND_CHG, C10.
    cyc(1'b1, 1'b0); check_all("t2_one1", C10,      1'b0, 1'b0);
    cyc(1'b1, 1'b0); check_all("t2_one2", VEND_CHG, 1'b1, 1'b1);
    cyc(1'b1, 1'b0); check_all("t2_one3", C10,      1'b0, 1'b0);
    cyc(1'b0, 1'b1); check_all("t2_half", VEND,     1'b1, 1'b0);
    cyc(1'b0, 1'b0); check_all("t2_idle", IDLE,     1'b0, 1'b0);

    // 3. half_in for three edges: C05, C10, VEND.
    cyc(1'b0, 1'b1); check_all("t3_half1", C05,  1'b0, 1'b0);
    cyc(1'b0, 1'b1); check_all("t3_half2", C10,  1'b0, 1'b0);
    cyc(1'b0, 1'b1); check_all("t3_half3", VEND, 1'b1, 1'b0);
    cyc(1'b0, 1'b0); check_all("t3_idle",  IDLE, 1'b0, 1'b0);

    // 4. one then half, then two idle edges.
    cyc(1'b1, 1'b0); check_all("t4_one",   C10,  1'b0, 1'b0);
    cyc(1'b0, 1'b1); check_all("t4_half",  VEND, 1'b1, 1'b0);
    cyc(1'b0, 1'b0); check_all("t4_idle1", IDLE, 1'b0, 1'b0);
    cyc(1'b0, 1'b0); check_all("t4_idle2", IDLE, 1'b0, 1'b0);

    // 5. half then one, then half, one, one.
    cyc(1'b0, 1'b1); check_all("t5_half",  C05,  1'b0, 1'b0);
    cyc(1'b1, 1'b0); check_all("t5_one",   VEND, 1'b1, 1'b0);
    cyc(1'b0, 1'b1); check_all("t5_half2", C05,  1'b0, 1'b0);
    cyc(1'b1, 1'b0); check_all("t5_one2",  VEND, 1'b1, 1'b0);
    cyc(1'b1, 1'b0); check_all("t5_one3",  C10,  1'b0, 1'b0);

    // 6. Return to IDLE, then both coins together: one wins.
    cyc(1'b0, 1'b1); check_all("t6_vend", VEND, 1'b1, 1'b0);
    cyc(1'b0, 1'b0); check_all("t6_idle", IDLE, 1'b0, 1'b0);
    cyc(1'b1, 1'b1); check_all("t6_both", C10,  1'b0, 1'b0);
    cyc(1'b0, 1'b0); check_all("t6_hold", C10,  1'b0, 1'b0);

    // Asynchronous reset mid-C10, then a coin held across an edge under reset.
    #10;
    reset = 1'b1;
    #1;
    check_all("t6_async_c10", IDLE, 1'b0, 1'b0);
    one_in = 1'b1;
    @(negedge clk);
    check_all("t6_coin_in_reset", IDLE, 1'b0, 1'b0);
    reset  = 1'b0;
    one_in = 1'b0;
    cyc(1'b0, 1'b1); check_all("t6_post_half", C05,  1'b0, 1'b0);
    cyc(1'b1, 1'b0); check_all("t6_post_one",  VEND, 1'b1, 1'b0);

    // Reset during VEND clears can_out immediately.
    #10;
    reset = 1'b1;
    #1;
    check_all("async_vend", IDLE, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b0, 1'b0); check_all("post_vend_idle", IDLE, 1'b0, 1'b0);

    // Reset during VEND_CHG clears both outputs immediately.
    cyc(1'b1, 1'b0); check_all("chg_one1", C10,      1'b0, 1'b0);
    cyc(1'b1, 1'b0); check_all("chg_one2", VEND_CHG, 1'b1, 1'b1);
    #10;
    reset = 1'b1;
    #1;
    check_all("async_vend_chg", IDLE, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b0, 1'b1); check_all("final_half", C05, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
